// File: rtl/move_queue_ctrl_pkg.sv
// move_queue_ctrl_pkg: shared state encoding and abort length for the move queue controller.
package move_queue_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, ABORT} state_t;
  localparam int ABORT_CYCLES = 2;
endpackage

// File: rtl/move_queue_ctrl_toggle_edge_detect.sv
// toggle_edge_detect: registers a toggle input and pulses for one cycle whenever it changes.
module toggle_edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic tog,
  output logic pulse
);
  logic tog_q, tog_d;
  always_comb begin
    tog_d = clr ? 1'b0 : tog;
    pulse = tog != tog_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) tog_q <= 1'b0;
    else tog_q <= tog_d;
  end
endmodule

// File: rtl/move_queue_ctrl.sv
// move_queue_ctrl: feeds moves into the DDA ring buffer, tracks occupancy and coordinates abort.
// Define MOVE_QUEUE_UNDERRUN_EN to add the saturating underrun_count output.
module move_queue_ctrl
  import move_queue_ctrl_pkg::*;
#(
  parameter int buffer_bits        = 2,
  parameter int buffer_size        = 4,
  parameter int move_duration_bits = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          cmd_valid,
  input  logic [move_duration_bits-1:0] cmd_duration,
  output logic                          cmd_ready,
  input  logic                          abort,
  input  logic                          move_done,
  output logic                          dda_resetn,
  output logic                          wr_en,
  output logic [buffer_bits-1:0]        wr_ind,
  output logic [move_duration_bits-1:0] wr_duration,
  output logic [buffer_size-1:0]        stepready,
  output logic [buffer_bits:0]          occupancy,
  output logic                          empty,
  output logic                          full
`ifdef MOVE_QUEUE_UNDERRUN_EN
  ,
  output logic [7:0]                    underrun_count
`endif
);
  state_t                        state_q, state_d;
  logic [1:0]                    cnt_q, cnt_d;
  logic [buffer_bits:0]          occ_q, occ_d;
  logic [buffer_bits-1:0]        wr_ptr_q, wr_ptr_d, wr_ind_q, wr_ind_d;
  logic [move_duration_bits-1:0] wr_duration_q, wr_duration_d;
  logic                          wr_en_q, wr_en_d;
  logic [buffer_size-1:0]        stepready_q, stepready_d;
  logic                          clr, accept, retire, done_pulse;

  toggle_edge_detect u_done (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clr),
    .tog    (move_done),
    .pulse  (done_pulse)
  );

  // Abort wins over accept and retire; the whole ABORT window keeps the queue cleared
  // so the DDA FSM's toggles coming out of its own reset cannot be miscounted.
  always_comb begin
    clr           = abort || state_q == ABORT;
    full          = occ_q == (buffer_bits+1)'(buffer_size);
    empty         = occ_q == '0;
    cmd_ready     = !full && state_q != ABORT && resetn;
    dda_resetn    = resetn && state_q != ABORT;
    accept        = cmd_valid && cmd_ready && !abort;
    retire        = done_pulse && !empty && !clr;
    occ_d         = clr ? '0 : occ_q + (buffer_bits+1)'(accept) - (buffer_bits+1)'(retire);
    wr_ptr_d      = clr ? '0 : wr_ptr_q + buffer_bits'(accept);
    wr_en_d       = accept;
    wr_ind_d      = clr ? '0 : accept ? wr_ptr_q : wr_ind_q;
    wr_duration_d = clr ? '0 : accept ? cmd_duration : wr_duration_q;
    stepready_d   = clr ? '0 : stepready_q ^ (buffer_size'(wr_en_q) << wr_ind_q);
    cnt_d         = (state_q == ABORT && !abort) ? cnt_q + 2'd1 : 2'd0;
    state_d       = abort ? ABORT
                  : state_q == ABORT ? (cnt_q == 2'(ABORT_CYCLES-1) ? IDLE : ABORT)
                  : occ_d != '0 ? RUN : IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      occ_q         <= '0;
      wr_ptr_q      <= '0;
      wr_ind_q      <= '0;
      wr_duration_q <= '0;
      wr_en_q       <= 1'b0;
      stepready_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      occ_q         <= occ_d;
      wr_ptr_q      <= wr_ptr_d;
      wr_ind_q      <= wr_ind_d;
      wr_duration_q <= wr_duration_d;
      wr_en_q       <= wr_en_d;
      stepready_q   <= stepready_d;
    end
  end

  assign occupancy   = occ_q;
  assign wr_en       = wr_en_q;
  assign wr_ind      = wr_ind_q;
  assign wr_duration = wr_duration_q;
  assign stepready   = stepready_q;

`ifdef MOVE_QUEUE_UNDERRUN_EN
  logic [7:0] und_q, und_d;
  always_comb begin
    und_d = (retire && occ_q == (buffer_bits+1)'(1) && !accept && und_q != 8'hff) ? und_q + 8'd1 : und_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) und_q <= '0;
    else und_q <= und_d;
  end
  assign underrun_count = und_q;
`endif
endmodule

// File: tb/tb_move_queue_ctrl.sv
// tb_move_queue_ctrl: directed self-checking bench for move_queue_ctrl.
module tb_move_queue_ctrl;
  logic        clk = 0;
  logic        resetn, cmd_valid, abort, move_done;
  logic [31:0] cmd_duration;
  logic        cmd_ready, dda_resetn, wr_en, empty, full;
  logic [1:0]  wr_ind;
  logic [31:0] wr_duration;
  logic [3:0]  stepready;
  logic [2:0]  occupancy;
`ifdef MOVE_QUEUE_UNDERRUN_EN
  logic [7:0]  underrun_count;
`endif
  int nchk = 0, nerr = 0;

  move_queue_ctrl dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_duration(cmd_duration),
    .cmd_ready(cmd_ready), .abort(abort), .move_done(move_done), .dda_resetn(dda_resetn),
    .wr_en(wr_en), .wr_ind(wr_ind), .wr_duration(wr_duration), .stepready(stepready),
    .occupancy(occupancy), .empty(empty), .full(full)
`ifdef MOVE_QUEUE_UNDERRUN_EN
    , .underrun_count(underrun_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 0; cmd_valid = 0; abort = 0; move_done = 0; cmd_duration = 0;
    repeat (3) step();
    nchk++; if (cmd_ready !== 1'b0) begin nerr++; $display("FAIL rst_cmd_ready got %b want 0", cmd_ready); end
    nchk++; if (empty !== 1'b1) begin nerr++; $display("FAIL rst_empty got %b want 1", empty); end
    nchk++; if (dda_resetn !== 1'b0) begin nerr++; $display("FAIL rst_dda_resetn got %b want 0", dda_resetn); end
    nchk++; if ({occupancy, stepready, wr_en, full} !== 9'd0) begin nerr++; $display("FAIL rst_outputs got %h want 0", {occupancy, stepready, wr_en, full}); end
`ifdef MOVE_QUEUE_UNDERRUN_EN
    nchk++; if (underrun_count !== 8'd0) begin nerr++; $display("FAIL rst_underrun got %0d want 0", underrun_count); end
`endif
    resetn = 1;
    step();
    nchk++; if (dda_resetn !== 1'b1) begin nerr++; $display("FAIL post_rst_dda_resetn got %b want 1", dda_resetn); end
    nchk++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL post_rst_cmd_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1; cmd_duration = 32'((i + 1) * 10);
      step();
      nchk++; if (wr_en !== 1'b1) begin nerr++; $display("FAIL fill_wr_en[%0d] got %b want 1", i, wr_en); end
      nchk++; if (wr_ind !== 2'(i)) begin nerr++; $display("FAIL fill_wr_ind[%0d] got %0d want %0d", i, wr_ind, i); end
      nchk++; if (wr_duration !== 32'((i + 1) * 10)) begin nerr++; $display("FAIL fill_wr_dur[%0d] got %0d want %0d", i, wr_duration, (i + 1) * 10); end
      nchk++; if (occupancy !== 3'(i + 1)) begin nerr++; $display("FAIL fill_occ[%0d] got %0d want %0d", i, occupancy, i + 1); end
    end
    nchk++; if (full !== 1'b1) begin nerr++; $display("FAIL fill_full got %b want 1", full); end
    nchk++; if (cmd_ready !== 1'b0) begin nerr++; $display("FAIL fill_cmd_ready got %b want 0", cmd_ready); end
    step();
    cmd_valid = 0;
    nchk++; if (occupancy !== 3'd4) begin nerr++; $display("FAIL fill_held_occ got %0d want 4", occupancy); end
    nchk++; if (wr_en !== 1'b0) begin nerr++; $display("FAIL fill_no_write_when_full got %b want 0", wr_en); end
    nchk++; if (stepready !== 4'b1111) begin nerr++; $display("FAIL fill_stepready got %b want 1111", stepready); end
  endtask

  task automatic test_retire();
    move_done = 1;
    step();
    nchk++; if (occupancy !== 3'd3) begin nerr++; $display("FAIL retire_occ got %0d want 3", occupancy); end
    nchk++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL retire_cmd_ready got %b want 1", cmd_ready); end
    cmd_valid = 1; cmd_duration = 50;
    step();
    cmd_valid = 0;
    nchk++; if ({wr_en, wr_ind} !== 3'b100) begin nerr++; $display("FAIL wrap_wr got en/ind %b want 100", {wr_en, wr_ind}); end
    nchk++; if (wr_duration !== 32'd50) begin nerr++; $display("FAIL wrap_dur got %0d want 50", wr_duration); end
    nchk++; if (stepready !== 4'b1111) begin nerr++; $display("FAIL wrap_stepready_early got %b want 1111", stepready); end
    step();
    nchk++; if (stepready !== 4'b1110) begin nerr++; $display("FAIL wrap_stepready got %b want 1110", stepready); end
    nchk++; if (occupancy !== 3'd4) begin nerr++; $display("FAIL wrap_occ got %0d want 4", occupancy); end
  endtask

  task automatic test_back_to_back();
    move_done = 0;
    step();
    move_done = 1;
    step();
    nchk++; if (occupancy !== 3'd2) begin nerr++; $display("FAIL simul_pre_occ got %0d want 2", occupancy); end
    cmd_valid = 1; cmd_duration = 60; move_done = 0;
    step();
    cmd_valid = 0;
    nchk++; if (occupancy !== 3'd2) begin nerr++; $display("FAIL simul_occ got %0d want 2", occupancy); end
    nchk++; if ({wr_en, wr_ind} !== 3'b101) begin nerr++; $display("FAIL simul_wr got en/ind %b want 101", {wr_en, wr_ind}); end
    step();
    nchk++; if (wr_en !== 1'b0) begin nerr++; $display("FAIL simul_single_pulse got %b want 0", wr_en); end
    nchk++; if (stepready !== 4'b1100) begin nerr++; $display("FAIL simul_stepready got %b want 1100", stepready); end
  endtask

  task automatic test_abort();
    cmd_valid = 1; cmd_duration = 70;
    step();
    nchk++; if (occupancy !== 3'd3) begin nerr++; $display("FAIL abort_pre_occ got %0d want 3", occupancy); end
    abort = 1; cmd_duration = 80;
    step();
    abort = 0;
    nchk++; if (dda_resetn !== 1'b0) begin nerr++; $display("FAIL abort_dda1 got %b want 0", dda_resetn); end
    nchk++; if (wr_en !== 1'b0) begin nerr++; $display("FAIL abort_wr_en1 got %b want 0", wr_en); end
    nchk++; if (cmd_ready !== 1'b0) begin nerr++; $display("FAIL abort_ready1 got %b want 0", cmd_ready); end
    nchk++; if ({occupancy, stepready, wr_ind} !== 9'd0) begin nerr++; $display("FAIL abort_clear got %h want 0", {occupancy, stepready, wr_ind}); end
    step();
    nchk++; if ({dda_resetn, cmd_ready, wr_en} !== 3'b000) begin nerr++; $display("FAIL abort_cycle2 got %b want 000", {dda_resetn, cmd_ready, wr_en}); end
    step();
    cmd_valid = 0;
    nchk++; if ({dda_resetn, cmd_ready} !== 2'b11) begin nerr++; $display("FAIL abort_exit got %b want 11", {dda_resetn, cmd_ready}); end
    nchk++; if ({occupancy, wr_en} !== 4'd0) begin nerr++; $display("FAIL abort_exit_idle got %h want 0", {occupancy, wr_en}); end
  endtask

  task automatic test_spurious();
    move_done = 1;
    step();
    step();
    nchk++; if ({occupancy, empty, cmd_ready, dda_resetn} !== 6'b000111) begin nerr++; $display("FAIL spurious got %b want 000111", {occupancy, empty, cmd_ready, dda_resetn}); end
  endtask

  task automatic test_underrun();
    for (int i = 0; i < 300; i++) begin
      cmd_valid = 1; cmd_duration = 5;
      step();
      cmd_valid = 0; move_done = ~move_done;
      step();
      if (i == 0) begin
        nchk++; if ({occupancy, empty} !== 4'b0001) begin nerr++; $display("FAIL drain_occ got %b want 0001", {occupancy, empty}); end
`ifdef MOVE_QUEUE_UNDERRUN_EN
        nchk++; if (underrun_count !== 8'd1) begin nerr++; $display("FAIL underrun_one got %0d want 1", underrun_count); end
`endif
      end
    end
    nchk++; if ({occupancy, empty} !== 4'b0001) begin nerr++; $display("FAIL drain_final got %b want 0001", {occupancy, empty}); end
`ifdef MOVE_QUEUE_UNDERRUN_EN
    nchk++; if (underrun_count !== 8'd255) begin nerr++; $display("FAIL underrun_sat got %0d want 255", underrun_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_retire();
    test_back_to_back();
    test_abort();
    test_spurious();
    test_underrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
